// File: rtl/axi_hpm0_reg_bank.sv
// AXI4 full slave register bank terminating the HPM0_FPD master port.
// Each channel owns four DATA_W words: three RW control words and one RO
// status word. Independent read and write engines, one burst each in flight.
module axi_hpm0_reg_bank #(
  parameter int DATA_W = 128,
  parameter int ADDR_W = 40,
  parameter int ID_W   = 16,
  parameter int NUM_CH = 8
) (
  input  logic                       pl_clk0,
  input  logic                       pl_reset0,
  input  logic [ID_W-1:0]            s_axi_awid,
  input  logic [ADDR_W-1:0]          s_axi_awaddr,
  input  logic [7:0]                 s_axi_awlen,
  input  logic [2:0]                 s_axi_awsize,
  input  logic [1:0]                 s_axi_awburst,
  input  logic                       s_axi_awvalid,
  output logic                       s_axi_awready,
  input  logic [DATA_W-1:0]          s_axi_wdata,
  input  logic [DATA_W/8-1:0]        s_axi_wstrb,
  input  logic                       s_axi_wlast,
  input  logic                       s_axi_wvalid,
  output logic                       s_axi_wready,
  output logic [ID_W-1:0]            s_axi_bid,
  output logic [1:0]                 s_axi_bresp,
  output logic                       s_axi_bvalid,
  input  logic                       s_axi_bready,
  input  logic [ID_W-1:0]            s_axi_arid,
  input  logic [ADDR_W-1:0]          s_axi_araddr,
  input  logic [7:0]                 s_axi_arlen,
  input  logic [2:0]                 s_axi_arsize,
  input  logic [1:0]                 s_axi_arburst,
  input  logic                       s_axi_arvalid,
  output logic                       s_axi_arready,
  output logic [ID_W-1:0]            s_axi_rid,
  output logic [DATA_W-1:0]          s_axi_rdata,
  output logic [1:0]                 s_axi_rresp,
  output logic                       s_axi_rlast,
  output logic                       s_axi_rvalid,
  input  logic                       s_axi_rready,
  output logic [NUM_CH*3*DATA_W-1:0] ctrl_out,
  output logic [NUM_CH*3-1:0]        ctrl_wr_pulse,
  input  logic [NUM_CH*DATA_W-1:0]   status_in
);

  localparam int BYTES = DATA_W / 8;
  localparam int LB    = $clog2(BYTES);
  localparam int IW    = ADDR_W - LB;
  localparam int NWORD = NUM_CH * 3;
  localparam int CHW   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [IW-1:0] IDX_LIMIT = IW'(4 * NUM_CH);
  localparam logic [2:0] SIZE_OK = 3'(LB);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  logic              init_q, init_d;
  w_state_t          w_state_q, w_state_d;
  logic [ID_W-1:0]   aw_id_q, aw_id_d;
  logic [IW-1:0]     w_idx_q, w_idx_d;
  logic [7:0]        w_cnt_q, w_cnt_d;
  logic              w_fixed_q, w_fixed_d;
  logic              w_bad_q, w_bad_d;
  logic [1:0]        b_resp_q, b_resp_d;
  logic [DATA_W-1:0] ctrl_q [NWORD];
  logic [DATA_W-1:0] ctrl_d [NWORD];
  logic [NWORD-1:0]  pulse_q, pulse_d;
  logic [1:0]        w_beat_resp;
  int                w_cidx;

  r_state_t          r_state_q, r_state_d;
  logic [ID_W-1:0]   ar_id_q, ar_id_d;
  logic [IW-1:0]     r_idx_q, r_idx_d;
  logic [7:0]        r_cnt_q, r_cnt_d;
  logic              r_fixed_q, r_fixed_d;
  logic              r_bad_q, r_bad_d;
  logic [DATA_W-1:0] r_data_q, r_data_d;
  logic [1:0]        r_resp_q, r_resp_d;
  logic              r_last_q, r_last_d;
  logic [IW-1:0]     ld_idx;
  logic              ld_bad;
  logic [DATA_W-1:0] ld_data;
  logic [1:0]        ld_resp;
  int                ld_cidx;
  int                ld_ch;

  // Sub-word address bits are ignored: accesses align down to a full word.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{s_axi_awaddr[LB-1:0], s_axi_araddr[LB-1:0]};

  assign init_d = 1'b1;

  // Write engine: captures AW, commits strobed bytes per beat, accumulates worst BRESP.
  always_comb begin
    w_state_d   = w_state_q;
    aw_id_d     = aw_id_q;
    w_idx_d     = w_idx_q;
    w_cnt_d     = w_cnt_q;
    w_fixed_d   = w_fixed_q;
    w_bad_d     = w_bad_q;
    b_resp_d    = b_resp_q;
    ctrl_d      = ctrl_q;
    pulse_d     = '0;
    w_beat_resp = RESP_OKAY;
    w_cidx      = int'(w_idx_q[2 +: CHW]) * 3 + int'(w_idx_q[1:0]);
    case (w_state_q)
      W_IDLE: begin
        if (init_q && s_axi_awvalid) begin
          aw_id_d   = s_axi_awid;
          w_idx_d   = s_axi_awaddr[ADDR_W-1:LB];
          w_cnt_d   = s_axi_awlen;
          w_fixed_d = (s_axi_awburst == 2'b00);
          w_bad_d   = (s_axi_awsize != SIZE_OK) || s_axi_awburst[1];
          b_resp_d  = RESP_OKAY;
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        if (s_axi_wvalid) begin
          if (w_bad_q) begin
            w_beat_resp = RESP_SLVERR;
          end else if (w_idx_q >= IDX_LIMIT) begin
            w_beat_resp = RESP_DECERR;
          end else if (w_idx_q[1:0] != 2'd3) begin
            for (int i = 0; i < NWORD; i++) begin
              if (i == w_cidx) begin
                for (int b = 0; b < BYTES; b++) begin
                  if (s_axi_wstrb[b]) ctrl_d[i][8*b +: 8] = s_axi_wdata[8*b +: 8];
                end
                pulse_d[i] = 1'b1;
              end
            end
          end
          if ((s_axi_wlast != (w_cnt_q == 8'd0)) && (w_beat_resp == RESP_OKAY))
            w_beat_resp = RESP_SLVERR;
          if (w_beat_resp > b_resp_q) b_resp_d = w_beat_resp;
          if (!w_fixed_q) w_idx_d = w_idx_q + IW'(1);
          if (w_cnt_q == 8'd0) w_state_d = W_RESP;
          else                 w_cnt_d   = w_cnt_q - 8'd1;
        end
      end
      W_RESP: begin
        if (s_axi_bready) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Decode of the read beat about to be loaded (first beat from AR, else the next index).
  always_comb begin
    ld_idx  = (r_state_q == R_IDLE) ? s_axi_araddr[ADDR_W-1:LB]
            : (r_fixed_q ? r_idx_q : r_idx_q + IW'(1));
    ld_bad  = (r_state_q == R_IDLE) ? ((s_axi_arsize != SIZE_OK) || s_axi_arburst[1]) : r_bad_q;
    ld_ch   = int'(ld_idx[2 +: CHW]);
    ld_cidx = ld_ch * 3 + int'(ld_idx[1:0]);
    ld_data = '0;
    ld_resp = RESP_OKAY;
    if (ld_bad) begin
      ld_resp = RESP_SLVERR;
    end else if (ld_idx >= IDX_LIMIT) begin
      ld_resp = RESP_DECERR;
    end else if (ld_idx[1:0] == 2'd3) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (c == ld_ch) ld_data = status_in[c*DATA_W +: DATA_W];
      end
    end else begin
      for (int i = 0; i < NWORD; i++) begin
        if (i == ld_cidx) ld_data = ctrl_q[i];
      end
    end
  end

  // Read engine: loads a beat on AR acceptance and on every non-final R handshake.
  always_comb begin
    r_state_d = r_state_q;
    ar_id_d   = ar_id_q;
    r_idx_d   = r_idx_q;
    r_cnt_d   = r_cnt_q;
    r_fixed_d = r_fixed_q;
    r_bad_d   = r_bad_q;
    r_data_d  = r_data_q;
    r_resp_d  = r_resp_q;
    r_last_d  = r_last_q;
    case (r_state_q)
      R_IDLE: begin
        if (init_q && s_axi_arvalid) begin
          ar_id_d   = s_axi_arid;
          r_idx_d   = ld_idx;
          r_cnt_d   = s_axi_arlen;
          r_fixed_d = (s_axi_arburst == 2'b00);
          r_bad_d   = ld_bad;
          r_data_d  = ld_data;
          r_resp_d  = ld_resp;
          r_last_d  = (s_axi_arlen == 8'd0);
          r_state_d = R_DATA;
        end
      end
      R_DATA: begin
        if (s_axi_rready) begin
          if (r_last_q) begin
            r_last_d  = 1'b0;
            r_state_d = R_IDLE;
          end else begin
            r_idx_d  = ld_idx;
            r_cnt_d  = r_cnt_q - 8'd1;
            r_data_d = ld_data;
            r_resp_d = ld_resp;
            r_last_d = (r_cnt_q == 8'd1);
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // State and register file; reset abandons any partial burst and clears control words.
  always_ff @(posedge pl_clk0 or posedge pl_reset0) begin
    if (pl_reset0) begin
      init_q    <= 1'b0;
      w_state_q <= W_IDLE;
      aw_id_q   <= '0;
      w_idx_q   <= '0;
      w_cnt_q   <= '0;
      w_fixed_q <= 1'b0;
      w_bad_q   <= 1'b0;
      b_resp_q  <= '0;
      for (int i = 0; i < NWORD; i++) ctrl_q[i] <= '0;
      pulse_q   <= '0;
      r_state_q <= R_IDLE;
      ar_id_q   <= '0;
      r_idx_q   <= '0;
      r_cnt_q   <= '0;
      r_fixed_q <= 1'b0;
      r_bad_q   <= 1'b0;
      r_data_q  <= '0;
      r_resp_q  <= '0;
      r_last_q  <= 1'b0;
    end else begin
      init_q    <= init_d;
      w_state_q <= w_state_d;
      aw_id_q   <= aw_id_d;
      w_idx_q   <= w_idx_d;
      w_cnt_q   <= w_cnt_d;
      w_fixed_q <= w_fixed_d;
      w_bad_q   <= w_bad_d;
      b_resp_q  <= b_resp_d;
      ctrl_q    <= ctrl_d;
      pulse_q   <= pulse_d;
      r_state_q <= r_state_d;
      ar_id_q   <= ar_id_d;
      r_idx_q   <= r_idx_d;
      r_cnt_q   <= r_cnt_d;
      r_fixed_q <= r_fixed_d;
      r_bad_q   <= r_bad_d;
      r_data_q  <= r_data_d;
      r_resp_q  <= r_resp_d;
      r_last_q  <= r_last_d;
    end
  end

  assign s_axi_awready = init_q && (w_state_q == W_IDLE);
  assign s_axi_wready  = (w_state_q == W_DATA);
  assign s_axi_bvalid  = (w_state_q == W_RESP);
  assign s_axi_bid     = aw_id_q;
  assign s_axi_bresp   = b_resp_q;
  assign s_axi_arready = init_q && (r_state_q == R_IDLE);
  assign s_axi_rvalid  = (r_state_q == R_DATA);
  assign s_axi_rid     = ar_id_q;
  assign s_axi_rdata   = r_data_q;
  assign s_axi_rresp   = r_resp_q;
  assign s_axi_rlast   = r_last_q;
  assign ctrl_wr_pulse = pulse_q;

  for (genvar g = 0; g < NWORD; g++) begin : g_ctrl_out
    assign ctrl_out[g*DATA_W +: DATA_W] = ctrl_q[g];
  end

endmodule

// File: tb/tb_axi_hpm0_reg_bank.sv
// Directed bench for axi_hpm0_reg_bank with a 2-channel, 128-bit instance.
module tb_axi_hpm0_reg_bank;
  localparam int DATA_W = 128;
  localparam int ADDR_W = 40;
  localparam int ID_W   = 16;
  localparam int NUM_CH = 2;

  logic pl_clk0 = 1'b0;
  logic pl_reset0 = 1'b1;
  logic [ID_W-1:0] s_axi_awid = '0, s_axi_arid = '0, s_axi_bid, s_axi_rid;
  logic [ADDR_W-1:0] s_axi_awaddr = '0, s_axi_araddr = '0;
  logic [7:0] s_axi_awlen = '0, s_axi_arlen = '0;
  logic [2:0] s_axi_awsize = '0, s_axi_arsize = '0;
  logic [1:0] s_axi_awburst = '0, s_axi_arburst = '0;
  logic s_axi_awvalid = 1'b0, s_axi_awready;
  logic [DATA_W-1:0] s_axi_wdata = '0, s_axi_rdata;
  logic [15:0] s_axi_wstrb = '0;
  logic s_axi_wlast = 1'b0, s_axi_wvalid = 1'b0, s_axi_wready;
  logic [1:0] s_axi_bresp, s_axi_rresp;
  logic s_axi_bvalid, s_axi_bready = 1'b0;
  logic s_axi_arvalid = 1'b0, s_axi_arready;
  logic s_axi_rlast, s_axi_rvalid, s_axi_rready = 1'b0;
  logic [NUM_CH*3*DATA_W-1:0] ctrl_out;
  logic [NUM_CH*3-1:0] ctrl_wr_pulse;
  logic [NUM_CH*DATA_W-1:0] status_in = '0;

  int total = 0;
  int bad = 0;
  logic [127:0] rd_data [0:3];
  logic [1:0]   rd_resp [0:3];
  logic         rd_last [0:3];
  logic [15:0]  rd_id;
  int           rd_cycles;

  localparam logic [127:0] PAT_A5  = 128'hA5A5_A5A5_A5A5_A5A5_A5A5_A5A5_A5A5_A5A5;
  localparam logic [127:0] BASE_S  = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [127:0] STAT0   = 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555;
  localparam logic [127:0] STAT1   = 128'hC0FF_EE00_1234_5678_9ABC_DEF0_0F0F_0F0F;
  localparam logic [127:0] BASE_E  = 128'hEEEE_0000_EEEE_0000_EEEE_0000_EEEE_0000;
  localparam logic [127:0] BASE_F  = 128'h2000_0000_0000_0000_0000_0000_0000_0000;
  localparam logic [127:0] NEW_C   = 128'h3333_3333_3333_3333_3333_3333_3333_3333;
  localparam logic [127:0] BASE_R  = 128'h4444_4444_4444_4444_4444_4444_4444_4444;

  axi_hpm0_reg_bank #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ID_W(ID_W), .NUM_CH(NUM_CH)) dut (
    .pl_clk0(pl_clk0), .pl_reset0(pl_reset0),
    .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
    .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready),
    .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
    .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .ctrl_out(ctrl_out), .ctrl_wr_pulse(ctrl_wr_pulse), .status_in(status_in)
  );

  // 100 MHz clock
  always #5 pl_clk0 = ~pl_clk0;

  function automatic logic [127:0] ctrl_word(input int c, input int k);
    return ctrl_out[(3*c+k)*DATA_W +: DATA_W];
  endfunction

  // Full write burst; beat i carries base+i, WLAST raised on beat last_at.
  task automatic axi_write(input logic [15:0] id, input logic [39:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input logic [127:0] base,
                           input logic [15:0] strb, input int last_at,
                           output logic [1:0] resp, output logic [15:0] bid, output bit ok);
    int n;
    ok = 1'b1; resp = '0; bid = '0;
    s_axi_awid = id; s_axi_awaddr = addr; s_axi_awlen = len;
    s_axi_awsize = size; s_axi_awburst = burst; s_axi_awvalid = 1'b1;
    n = 0;
    while (!s_axi_awready && n < 50) begin @(negedge pl_clk0); n++; end
    if (!s_axi_awready) ok = 1'b0;
    @(negedge pl_clk0);
    s_axi_awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      s_axi_wvalid = 1'b1; s_axi_wdata = base + 128'(i);
      s_axi_wstrb = strb; s_axi_wlast = (i == last_at);
      n = 0;
      while (!s_axi_wready && n < 50) begin @(negedge pl_clk0); n++; end
      if (!s_axi_wready) ok = 1'b0;
      @(negedge pl_clk0);
    end
    s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
    n = 0;
    while (!s_axi_bvalid && n < 50) begin @(negedge pl_clk0); n++; end
    if (!s_axi_bvalid) ok = 1'b0;
    resp = s_axi_bresp; bid = s_axi_bid;
    s_axi_bready = 1'b1;
    @(negedge pl_clk0);
    s_axi_bready = 1'b0;
  endtask

  // Full read burst with RREADY held high; beats land in rd_* arrays.
  task automatic axi_read(input logic [15:0] id, input logic [39:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst, output bit ok);
    int n;
    ok = 1'b1;
    s_axi_arid = id; s_axi_araddr = addr; s_axi_arlen = len;
    s_axi_arsize = size; s_axi_arburst = burst; s_axi_arvalid = 1'b1;
    n = 0;
    while (!s_axi_arready && n < 50) begin @(negedge pl_clk0); n++; end
    if (!s_axi_arready) ok = 1'b0;
    @(negedge pl_clk0);
    s_axi_arvalid = 1'b0;
    s_axi_rready = 1'b1;
    rd_cycles = 0;
    rd_id = s_axi_rid;
    for (int i = 0; i <= int'(len); i++) begin
      n = 0;
      while (!s_axi_rvalid && n < 50) begin @(negedge pl_clk0); n++; rd_cycles++; end
      if (!s_axi_rvalid) ok = 1'b0;
      if (i < 4) begin
        rd_data[i] = s_axi_rdata; rd_resp[i] = s_axi_rresp; rd_last[i] = s_axi_rlast;
      end
      @(negedge pl_clk0);
      rd_cycles++;
    end
    s_axi_rready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge pl_clk0);
    total++;
    if ({s_axi_awready, s_axi_arready, s_axi_wready, s_axi_bvalid, s_axi_rvalid, s_axi_rlast} !== 6'b0) begin
      bad++; $display("[TB] FAIL reset_handshakes got=%b want=000000",
        {s_axi_awready, s_axi_arready, s_axi_wready, s_axi_bvalid, s_axi_rvalid, s_axi_rlast});
    end
    total++;
    if (ctrl_out !== '0 || ctrl_wr_pulse !== '0) begin
      bad++; $display("[TB] FAIL reset_ctrl got pulse=%h want ctrl=0 pulse=0", ctrl_wr_pulse);
    end
    total++;
    if ({s_axi_bresp, s_axi_rresp, s_axi_bid, s_axi_rid} !== '0 || s_axi_rdata !== '0) begin
      bad++; $display("[TB] FAIL reset_resp got bresp=%0d rresp=%0d want 0", s_axi_bresp, s_axi_rresp);
    end
    pl_reset0 = 1'b0;
    #1;
    total++;
    if (s_axi_awready !== 1'b0) begin
      bad++; $display("[TB] FAIL awready_before_clock got=%b want=0", s_axi_awready);
    end
    @(negedge pl_clk0);
    total++;
    if (s_axi_awready !== 1'b1 || s_axi_arready !== 1'b1) begin
      bad++; $display("[TB] FAIL ready_after_release got aw=%b ar=%b want 1 1", s_axi_awready, s_axi_arready);
    end
  endtask

  task automatic test_single_write();
    s_axi_awid = 16'h3; s_axi_awaddr = 40'h10; s_axi_awlen = 8'd0;
    s_axi_awsize = 3'd4; s_axi_awburst = 2'b01; s_axi_awvalid = 1'b1;
    @(negedge pl_clk0);
    s_axi_awvalid = 1'b0;
    total++;
    if (s_axi_wready !== 1'b1 || s_axi_bvalid !== 1'b0) begin
      bad++; $display("[TB] FAIL sw_wready got wready=%b bvalid=%b want 1 0", s_axi_wready, s_axi_bvalid);
    end
    s_axi_wvalid = 1'b1; s_axi_wdata = PAT_A5; s_axi_wstrb = 16'hFFFF; s_axi_wlast = 1'b1;
    @(negedge pl_clk0);
    s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
    total++;
    if (ctrl_word(0, 1) !== PAT_A5) begin
      bad++; $display("[TB] FAIL sw_data got=%h want=%h", ctrl_word(0, 1), PAT_A5);
    end
    total++;
    if (ctrl_wr_pulse !== 6'b000010) begin
      bad++; $display("[TB] FAIL sw_pulse got=%b want=000010", ctrl_wr_pulse);
    end
    total++;
    if (s_axi_bvalid !== 1'b1 || s_axi_bid !== 16'h3 || s_axi_bresp !== 2'b00) begin
      bad++; $display("[TB] FAIL sw_bresp got v=%b id=%h resp=%0d want 1 3 0", s_axi_bvalid, s_axi_bid, s_axi_bresp);
    end
    @(negedge pl_clk0);
    total++;
    if (ctrl_wr_pulse !== 6'b0 || s_axi_bvalid !== 1'b1 || s_axi_bid !== 16'h3) begin
      bad++; $display("[TB] FAIL sw_hold got pulse=%b bvalid=%b bid=%h want 0 1 3", ctrl_wr_pulse, s_axi_bvalid, s_axi_bid);
    end
    s_axi_bready = 1'b1;
    @(negedge pl_clk0);
    s_axi_bready = 1'b0;
    total++;
    if (s_axi_bvalid !== 1'b0 || s_axi_awready !== 1'b1) begin
      bad++; $display("[TB] FAIL sw_after_b got bvalid=%b awready=%b want 0 1", s_axi_bvalid, s_axi_awready);
    end
  endtask

  task automatic test_strobed_incr();
    logic [1:0] resp; logic [15:0] bid; bit ok;
    logic [127:0] exp_d [0:3];
    axi_write(16'h5, 40'h0, 8'd3, 3'd4, 2'b01, BASE_S, 16'h000F, 3, resp, bid, ok);
    total++;
    if (!ok || resp !== 2'b00 || bid !== 16'h5) begin
      bad++; $display("[TB] FAIL strobe_bresp got ok=%0d resp=%0d bid=%h want 1 0 5", ok, resp, bid);
    end
    exp_d[0] = {96'h0, 32'h7654_3210};
    exp_d[1] = {PAT_A5[127:32], 32'h7654_3211};
    exp_d[2] = {96'h0, 32'h7654_3212};
    exp_d[3] = STAT0;
    for (int k = 0; k < 3; k++) begin
      total++;
      if (ctrl_word(0, k) !== exp_d[k]) begin
        bad++; $display("[TB] FAIL strobe_word%0d got=%h want=%h", k, ctrl_word(0, k), exp_d[k]);
      end
    end
    status_in[0 +: 128] = STAT0;
    axi_read(16'h7, 40'h0, 8'd3, 3'd4, 2'b01, ok);
    total++;
    if (!ok || rd_cycles != 4 || rd_id !== 16'h7) begin
      bad++; $display("[TB] FAIL incr_read_timing got ok=%0d cycles=%0d rid=%h want 1 4 7", ok, rd_cycles, rd_id);
    end
    for (int k = 0; k < 4; k++) begin
      total++;
      if (rd_data[k] !== exp_d[k] || rd_resp[k] !== 2'b00 || rd_last[k] !== (k == 3)) begin
        bad++; $display("[TB] FAIL incr_read_beat%0d got d=%h r=%0d l=%b want d=%h r=0 l=%0d",
          k, rd_data[k], rd_resp[k], rd_last[k], exp_d[k], (k == 3));
      end
    end
    total++;
    if (s_axi_rvalid !== 1'b0) begin
      bad++; $display("[TB] FAIL incr_read_end got rvalid=%b want 0", s_axi_rvalid);
    end
  endtask

  task automatic test_overflow();
    logic [1:0] resp; logic [15:0] bid; bit ok;
    logic [127:0] exp_d [0:3];
    logic [1:0]   exp_r [0:3];
    axi_write(16'h1, 40'h60, 8'd0, 3'd4, 2'b01, 128'h1111, 16'hFFFF, 0, resp, bid, ok);
    status_in[128 +: 128] = STAT1;
    exp_d[0] = 128'h1111; exp_d[1] = STAT1; exp_d[2] = '0; exp_d[3] = '0;
    exp_r[0] = 2'b00; exp_r[1] = 2'b00; exp_r[2] = 2'b11; exp_r[3] = 2'b11;
    axi_read(16'h2, 40'h60, 8'd3, 3'd4, 2'b01, ok);
    total++;
    if (!ok) begin
      bad++; $display("[TB] FAIL ovf_read_done got ok=0 want 1");
    end
    for (int k = 0; k < 4; k++) begin
      total++;
      if (rd_data[k] !== exp_d[k] || rd_resp[k] !== exp_r[k] || rd_last[k] !== (k == 3)) begin
        bad++; $display("[TB] FAIL ovf_beat%0d got d=%h r=%0d l=%b want d=%h r=%0d",
          k, rd_data[k], rd_resp[k], rd_last[k], exp_d[k], exp_r[k]);
      end
    end
    axi_write(16'h1, 40'h80, 8'd0, 3'd4, 2'b01, 128'h9999, 16'hFFFF, 0, resp, bid, ok);
    total++;
    if (!ok || resp !== 2'b11) begin
      bad++; $display("[TB] FAIL ovf_write got ok=%0d resp=%0d want 1 3", ok, resp);
    end
  endtask

  task automatic test_illegal();
    logic [1:0] resp; logic [15:0] bid; bit ok;
    axi_write(16'h2, 40'h20, 8'd0, 3'd2, 2'b01, {128{1'b1}}, 16'hFFFF, 0, resp, bid, ok);
    total++;
    if (!ok || resp !== 2'b10 || ctrl_word(0, 2) !== {96'h0, 32'h7654_3212}) begin
      bad++; $display("[TB] FAIL bad_size got ok=%0d resp=%0d word=%h want 1 2 unchanged", ok, resp, ctrl_word(0, 2));
    end
    axi_read(16'h4, 40'h0, 8'd1, 3'd4, 2'b10, ok);
    for (int k = 0; k < 2; k++) begin
      total++;
      if (!ok || rd_data[k] !== '0 || rd_resp[k] !== 2'b10 || rd_last[k] !== (k == 1)) begin
        bad++; $display("[TB] FAIL wrap_beat%0d got ok=%0d d=%h r=%0d l=%b want d=0 r=2",
          k, ok, rd_data[k], rd_resp[k], rd_last[k]);
      end
    end
    axi_write(16'h6, 40'h40, 8'd3, 3'd4, 2'b01, BASE_E, 16'hFFFF, 1, resp, bid, ok);
    total++;
    if (!ok || resp !== 2'b10 || bid !== 16'h6) begin
      bad++; $display("[TB] FAIL early_wlast got ok=%0d resp=%0d bid=%h want 1 2 6", ok, resp, bid);
    end
  endtask

  task automatic test_fixed();
    logic [1:0] resp; logic [15:0] bid; bit ok;
    axi_write(16'h8, 40'h50, 8'd1, 3'd4, 2'b00, BASE_F, 16'hFFFF, 1, resp, bid, ok);
    total++;
    if (!ok || resp !== 2'b00 || ctrl_word(1, 1) !== BASE_F + 128'd1 || ctrl_word(1, 2) !== BASE_E + 128'd2) begin
      bad++; $display("[TB] FAIL fixed_write got ok=%0d resp=%0d w1=%h w2=%h want w1=%h w2=%h",
        ok, resp, ctrl_word(1, 1), ctrl_word(1, 2), BASE_F + 128'd1, BASE_E + 128'd2);
    end
  endtask

  task automatic test_back_to_back();
    s_axi_awid = 16'h9; s_axi_awaddr = 40'h40; s_axi_awlen = 8'd0;
    s_axi_awsize = 3'd4; s_axi_awburst = 2'b01; s_axi_awvalid = 1'b1;
    @(negedge pl_clk0);
    s_axi_awvalid = 1'b0;
    s_axi_wvalid = 1'b1; s_axi_wdata = NEW_C; s_axi_wstrb = 16'hFFFF; s_axi_wlast = 1'b1;
    s_axi_arid = 16'hA; s_axi_araddr = 40'h40; s_axi_arlen = 8'd0;
    s_axi_arsize = 3'd4; s_axi_arburst = 2'b01; s_axi_arvalid = 1'b1;
    @(negedge pl_clk0);
    s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0; s_axi_arvalid = 1'b0;
    total++;
    if (s_axi_rvalid !== 1'b1 || s_axi_rdata !== BASE_E || s_axi_rlast !== 1'b1 || s_axi_rid !== 16'hA) begin
      bad++; $display("[TB] FAIL conc_old_value got v=%b d=%h l=%b id=%h want 1 %h 1 a",
        s_axi_rvalid, s_axi_rdata, s_axi_rlast, s_axi_rid, BASE_E);
    end
    total++;
    if (ctrl_word(1, 0) !== NEW_C || s_axi_bvalid !== 1'b1) begin
      bad++; $display("[TB] FAIL conc_write got=%h bvalid=%b want=%h 1", ctrl_word(1, 0), s_axi_bvalid, NEW_C);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge pl_clk0);
      total++;
      if (s_axi_rvalid !== 1'b1 || s_axi_rdata !== BASE_E || s_axi_rresp !== 2'b00 ||
          s_axi_bvalid !== 1'b1 || s_axi_bid !== 16'h9 || s_axi_bresp !== 2'b00) begin
        bad++; $display("[TB] FAIL stall_hold%0d got rv=%b d=%h bv=%b bid=%h", k, s_axi_rvalid, s_axi_rdata, s_axi_bvalid, s_axi_bid);
      end
    end
    s_axi_bready = 1'b1;
    @(negedge pl_clk0);
    s_axi_bready = 1'b0;
    total++;
    if (s_axi_bvalid !== 1'b0 || s_axi_rvalid !== 1'b1 || s_axi_rdata !== BASE_E) begin
      bad++; $display("[TB] FAIL conc_b_done got bv=%b rv=%b d=%h want 0 1 old", s_axi_bvalid, s_axi_rvalid, s_axi_rdata);
    end
    s_axi_rready = 1'b1;
    @(negedge pl_clk0);
    s_axi_rready = 1'b0;
    total++;
    if (s_axi_rvalid !== 1'b0) begin
      bad++; $display("[TB] FAIL conc_r_done got rvalid=%b want 0", s_axi_rvalid);
    end
  endtask

  task automatic test_reset_mid_burst();
    s_axi_awid = 16'h1; s_axi_awaddr = 40'h0; s_axi_awlen = 8'd3;
    s_axi_awsize = 3'd4; s_axi_awburst = 2'b01; s_axi_awvalid = 1'b1;
    @(negedge pl_clk0);
    s_axi_awvalid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      s_axi_wvalid = 1'b1; s_axi_wdata = BASE_R + 128'(i); s_axi_wstrb = 16'hFFFF; s_axi_wlast = 1'b0;
      @(negedge pl_clk0);
    end
    s_axi_wvalid = 1'b0;
    total++;
    if (ctrl_word(0, 1) !== BASE_R + 128'd1) begin
      bad++; $display("[TB] FAIL partial_commit got=%h want=%h", ctrl_word(0, 1), BASE_R + 128'd1);
    end
    pl_reset0 = 1'b1;
    #1;
    total++;
    if (ctrl_out !== '0 || s_axi_bvalid !== 1'b0 || s_axi_awready !== 1'b0) begin
      bad++; $display("[TB] FAIL mid_reset got bvalid=%b awready=%b want ctrl=0 0 0", s_axi_bvalid, s_axi_awready);
    end
    repeat (2) @(negedge pl_clk0);
    pl_reset0 = 1'b0;
    #1;
    total++;
    if (s_axi_awready !== 1'b0) begin
      bad++; $display("[TB] FAIL mid_release_early got awready=%b want 0", s_axi_awready);
    end
    @(negedge pl_clk0);
    total++;
    if (s_axi_awready !== 1'b1 || s_axi_wready !== 1'b0 || s_axi_bvalid !== 1'b0) begin
      bad++; $display("[TB] FAIL mid_release got aw=%b w=%b b=%b want 1 0 0", s_axi_awready, s_axi_wready, s_axi_bvalid);
    end
    repeat (3) @(negedge pl_clk0);
    total++;
    if (s_axi_bvalid !== 1'b0 || ctrl_out !== '0) begin
      bad++; $display("[TB] FAIL mid_no_resp got bvalid=%b want 0 and ctrl=0", s_axi_bvalid);
    end
  endtask

  // Guard against a stuck run
  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  // Scenario sequence
  initial begin
    test_reset();
    test_single_write();
    test_strobed_incr();
    test_overflow();
    test_illegal();
    test_fixed();
    test_back_to_back();
    test_reset_mid_burst();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
